// File: rtl/tx_arbiter_if.sv
// +------------------------------------------------------------------+
// | tx_arbiter_if : requester / transmitter bundle for tx_arbiter    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               output_busy;
  logic               output_en;
  logic [7:0]         output_data;
  logic               grant_active;
  logic [GW-1:0]      grant_id;
  logic               stall_abort;

  // master: requesters plus the transmitter's busy flag
  modport master (
    output req_valid, req_data, req_last, output_busy,
    input  req_ready, output_en, output_data, grant_active, grant_id, stall_abort
  );

  // slave: the arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, output_busy,
    output req_ready, output_en, output_data, grant_active, grant_id, stall_abort
  );
endinterface

`default_nettype wire

// File: rtl/tx_arbiter.sv
// +------------------------------------------------------------------+
// | tx_arbiter : round-robin, message-granular byte port arbiter     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  tx_arbiter_if.slave bus
);
  localparam int          GW            = $clog2(N_REQ);
  localparam logic [15:0] STALL_LIMIT_W = 16'(STALL_LIMIT);
  localparam bit          WDOG_EN       = (STALL_LIMIT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic          grant_active_q, grant_active_d;
  logic          output_en_q, output_en_d;
  logic [7:0]    output_data_q, output_data_d;
  logic          stall_abort_q, stall_abort_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic             hold_free;
  logic [N_REQ-1:0] req_ready;
  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N_REQ)) s = s - 32'(N_REQ);
    return s[GW-1:0];
  endfunction

  assign hold_free = !output_en_q || !bus.output_busy;
  assign g_valid   = bus.req_valid[grant_id_q];
  assign g_last    = bus.req_last[grant_id_q];
  assign g_data    = bus.req_data[{grant_id_q, 3'b000} +: 8];

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < 32'(N_REQ); i++) begin
      if (!pick_found && bus.req_valid[wrap_inc(rr_ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_inc(rr_ptr_q, i);
      end
    end
  end

  // Ready never looks at req_valid, so requesters may derive valid from ready.
  always_comb begin
    req_ready = '0;
    if (state_q == S_SEND) req_ready[grant_id_q] = hold_free;
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    output_en_d    = output_en_q;
    output_data_d  = output_data_q;
    stall_abort_d  = 1'b0;
    stall_cnt_d    = stall_cnt_q;

    if (output_en_q && !bus.output_busy) output_en_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          rr_ptr_d       = wrap_inc(pick_idx, 1);
          stall_cnt_d    = '0;
          state_d        = S_SEND;
        end
      end
      S_SEND: begin
        if (g_valid && hold_free) begin
          output_data_d = g_data;
          output_en_d   = 1'b1;
          stall_cnt_d   = '0;
          if (g_last) state_d = S_DRAIN;
        end else if (hold_free) begin
          // Starved: port offered but owner has nothing; counter saturates.
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
            if (WDOG_EN && stall_cnt_d == STALL_LIMIT_W) begin
              stall_abort_d = 1'b1;
              state_d       = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (hold_free) begin
          output_en_d    = 1'b0;
          grant_active_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      output_en_q    <= 1'b0;
      output_data_q  <= 8'h00;
      stall_abort_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      output_en_q    <= output_en_d;
      output_data_q  <= output_data_d;
      stall_abort_q  <= stall_abort_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.output_en    = output_en_q;
  assign bus.output_data  = output_data_q;
  assign bus.grant_active = grant_active_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.stall_abort  = stall_abort_q;

endmodule

`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares the single byte-wide transmit port (`output_en` / `output_data` / `output_busy`) between N_REQ message producers, such as per-part puzzle solvers and the hex/decimal result formatters. A grant is held for a whole message, from the first byte to the byte flagged `last`, so messages never interleave on the wire. A stall watchdog reclaims the port from a requester that stops supplying bytes mid-message. The block sits between the solver blocks and the UART transmitter.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8.
- STALL_LIMIT, 1024, consecutive starved cycles before a grant is revoked; 0 disables the watchdog; legal range 0..65535.
- GW, $clog2(N_REQ), width of grant_id (derived, not overridable).

- clk  input  1  the single clock; all logic is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i is high when requester i offers a byte.
- req_data  input  8*N_REQ  byte from requester i on bits [8i+7:8i].
- req_last  input  N_REQ  bit i marks the offered byte as the final byte of the message.
- req_ready  output  N_REQ  bit i high means requester i's byte is accepted this cycle if req_valid[i] is high; combinational.
- output_busy  input  1  the transmitter cannot take a byte this cycle.
- output_en  output  1  registered; output_data is valid.
- output_data  output  8  registered byte to transmit.
- grant_active  output  1  registered; a requester currently owns the port.
- grant_id  output  GW  registered index of the owner; holds its last value when idle.
- stall_abort  output  1  registered one-cycle pulse when the watchdog revokes a grant.

## Operation
- A byte is consumed by the transmitter in a cycle where output_en=1 and output_busy=0.
- The output stage is a 1-deep hold register made of output_en and output_data. It is free in a cycle when output_en=0, or when output_en=1 and output_busy=0.
- States:
  - IDLE
    - No owner; req_ready = 0.
    - If any req_valid bit is set, pick the first set bit searching upward from rr_ptr with wrap-around.
    - On a pick: grant_id <= winner, grant_active <= 1, rr_ptr <= (winner+1) mod N_REQ, go to SEND.
    - If no bit is set, stay in IDLE.
  - SEND
    - req_ready[grant_id] = hold register free; all other req_ready bits = 0.
    - On acceptance (req_valid[g] and req_ready[g]): output_data <= byte, output_en <= 1, stall counter <= 0.
    - If the accepted byte had req_last set, go to DRAIN.
    - If the hold register is consumed with no new acceptance, output_en <= 0.
  - DRAIN
    - req_ready = 0.
    - When the hold register is free (consumed or already empty): output_en <= 0, grant_active <= 0, go to IDLE.
- Watchdog (SEND only):
  - The stall counter increments in each cycle where req_ready[g]=1 and req_valid[g]=0.
  - When it reaches STALL_LIMIT (and STALL_LIMIT is nonzero): stall_abort <= 1 for one cycle, go to DRAIN.
  - A byte already held in the register is still transmitted.
  - The counter saturates and never wraps. Its width is 16 bits.
- Fairness: the pointer advances past the winner, so a continuously requesting set of N_REQ requesters is served in index order 0,1,…,N_REQ-1,0,…
- req_valid on requesters without a grant is ignored; their bytes are never consumed.
- A message of exactly one byte (req_last set on the first byte) is legal: SEND lasts one cycle, then DRAIN.

## Timing
- Reset values: output_en 0, output_data 8'h00, grant_active 0, grant_id 0, stall_abort 0, rr_ptr 0, state IDLE, stall counter 0. req_ready is 0 because the state is IDLE.
- Reset mid-message: a held byte is discarded; the requester's partial message is not resumed. The requester must restart it after reset.
- Arbitration latency: req_valid rises at cycle t in IDLE → grant_active=1 and req_ready[g]=1 at t+1 → first output_en=1 at t+2.
- Throughput: with output_busy=0 and the requester always valid, one byte per cycle.
- Message gap: last byte consumed at cycle c → IDLE at c+1 → next grant at c+2 → next output_en at c+3.
- Simultaneous consume-and-accept in SEND: output_en stays 1 and output_data updates; no bubble.
- output_data is held stable while output_en=1 and output_busy=1.
- req_ready depends combinationally on output_busy, state and grant_id. It does not depend on req_valid, so there is no combinational loop through requesters.

## Test plan
- Single requester, N_REQ=4, req 2 sends "ab\n" with last on '\n', output_busy=0 → output bytes 0x61, 0x62, 0x0A on consecutive cycles starting 2 cycles after req_valid; grant_id=2; grant_active drops 1 cycle after 0x0A is consumed.
- All 4 requesters valid continuously, each sending 2-byte messages → grant order 0,1,2,3,0; messages never interleave; bytes within each message are in order.
- Backpressure: output_busy=1 for 5 cycles mid-message → output_data stable and req_ready low throughout; no byte is lost or duplicated once busy clears.
- Watchdog, STALL_LIMIT=8: req 1 sends one byte, then deasserts req_valid → stall_abort pulses exactly once, 8 starved cycles after the byte is accepted; the held byte is still sent; req 3 waiting is granted next.
- Reset asserted while output_en=1 with output_busy=1 → next cycle output_en=0, grant_active=0, all req_ready=0; after release, arbitration restarts from requester 0.
- One-byte message with req_last on the first byte, while requester 0 also waits → exactly one byte is sent, then requester 0 is granted 2 cycles after that byte is consumed.
